// File: rtl/div_ctrl.sv
// Iterative 32-bit restoring divider for DIV/DIVU. It takes operands through a start/ready handshake.
// It holds {remainder, quotient} until the requester releases start_i.
module div_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_rem, w_rem_nxt;
    logic [31:0] r_quot, w_quot_nxt;
    logic [31:0] r_divisor, w_divisor_nxt;
    logic        r_neg_q, w_neg_q_nxt;
    logic        r_neg_r, w_neg_r_nxt;
    logic [63:0] r_result, w_result_nxt;
    logic        r_ready, w_ready_nxt;

    logic [31:0] w_abs1, w_abs2;
    logic [32:0] w_shift, w_diff;
    logic [31:0] w_quot_fin, w_rem_fin;

    assign w_abs1 = (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i : opdata2_i;

    // The partial remainder is always below the divisor after a restore, so it fits in 32 bits.
    // Only the shifted value needs the 33rd bit.
    assign w_shift    = {r_rem, r_quot[31]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_quot_fin = r_neg_q ? 32'd0 - r_quot : r_quot;
    assign w_rem_fin  = r_neg_r ? 32'd0 - r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FREE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rem     <= w_rem_nxt;
            r_quot    <= w_quot_nxt;
            r_divisor <= w_divisor_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rem_nxt     = r_rem;
        w_quot_nxt    = r_quot;
        w_divisor_nxt = r_divisor;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;
        unique case (r_state)
            S_FREE: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
                if (start_i && !annul_i) begin
                    w_neg_q_nxt = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    w_neg_r_nxt = signed_div_i && opdata1_i[31];
                    if (opdata2_i == 32'd0) begin
                        w_state_nxt = S_BYZERO;
                    end else begin
                        w_quot_nxt    = w_abs1;
                        w_divisor_nxt = w_abs2;
                        w_rem_nxt     = '0;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_ON;
                    end
                end
            end
            S_BYZERO: begin
                if (annul_i || !start_i) begin
                    w_state_nxt = S_FREE;
                end else begin
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = S_END;
                end
            end
            S_ON: begin
                if (annul_i || !start_i) begin
                    w_state_nxt = S_FREE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != 6'd32) begin
                    if (!w_diff[32]) begin
                        w_rem_nxt  = w_diff[31:0];
                        w_quot_nxt = {r_quot[30:0], 1'b1};
                    end else begin
                        w_rem_nxt  = w_shift[31:0];
                        w_quot_nxt = {r_quot[30:0], 1'b0};
                    end
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    w_result_nxt = {w_rem_fin, w_quot_fin};
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = S_END;
                end
            end
            S_END: begin
                w_ready_nxt = 1'b1;
                if (!start_i) begin
                    w_state_nxt  = S_FREE;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = S_FREE;
        endcase
    end

    always_comb begin
        busy_o = (r_state == S_BYZERO) || (r_state == S_ON);
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized plus directed bench for div_ctrl.
// A transaction-level reference model predicts ready/busy/result on every cycle.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdiv = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    div_ctrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signed_div_i (sdiv),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
        int sa;
        int sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return '0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Model: cycles of busy remaining, then a done phase holding the result until start drops.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_pend = '0;
        end else if (m_done) begin
            if (!start) begin
                m_done = 1'b0;
                m_res  = '0;
            end
        end else if (m_left > 0) begin
            if (annul || !start) begin
                m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end
        end else if (start && !annul) begin
            m_pend = ref_div(op1, op2, sdiv);
            m_left = (op2 == 32'd0) ? 1 : 33;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("ready", {63'd0, ready_o}, {63'd0, m_done});
        chk("busy", {63'd0, busy_o}, {63'd0, (m_left > 0)});
        chk("result", result_o, m_res);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit lit, input logic [63:0] exp_lit, input int hold);
        int k;
        int nb;
        op1   = a;
        op2   = b;
        sdiv  = s;
        start = 1'b1;
        annul = 1'b0;
        k  = 0;
        nb = 0;
        do begin
            tick();
            k++;
            if (busy_o) nb++;
        end while (!ready_o && k < 40);
        chk("latency", 64'(k), (b == 32'd0) ? 64'd2 : 64'd34);
        chk("busy_cycles", 64'(nb), (b == 32'd0) ? 64'd1 : 64'd33);
        if (lit) chk("result_lit", result_o, exp_lit);
        repeat (hold) tick();
        if (lit) chk("hold_result", result_o, exp_lit);
        start = 1'b0;
        tick();
        chk("drop_ready", {63'd0, ready_o}, 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        chk("model_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h0000_0002_0000_000E);
        chk("model_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_7_m2", ref_div(32'd7, 32'hFFFF_FFFE, 1'b1), 64'h0000_0001_FFFF_FFFD);

        #12;
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        rst_n = 1'b1;
        tick();

        run(32'd100, 32'd7, 1'b0, 1'b1, 64'h0000_0002_0000_000E, 0);
        run(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        run(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 64'h0000_0001_FFFF_FFFD, 0);
        run(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 64'h0000_0001_7FFF_FFFC, 0);
        run(32'd1234, 32'd0, 1'b1, 1'b1, 64'd0, 0);
        run(32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 64'd0, 2);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 5);

        // Annul mid-iteration, then restart immediately with new operands.
        op1 = 32'h1234_5678; op2 = 32'd3; sdiv = 1'b0; start = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        tick();
        chk("annul_busy", {63'd0, busy_o}, 64'd0);
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        run(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 64'h0000_000F_0FFF_FFFF, 0);

        // Asynchronous reset between clock edges mid-division.
        op1 = 32'd1234567; op2 = 32'd89; sdiv = 1'b1; start = 1'b1;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", {63'd0, ready_o}, 64'd0);
        chk("async_busy", {63'd0, busy_o}, 64'd0);
        chk("async_result", result_o, 64'd0);
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run(32'd1000, 32'd10, 1'b0, 1'b1, 64'h0000_0000_0000_0064, 0);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            logic [31:0] b;
            int kind;
            a    = $urandom;
            kind = $urandom_range(0, 4);
            case (kind)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                op1 = a; op2 = b; sdiv = 1'($urandom_range(0, 1)); start = 1'b1;
                repeat ($urandom_range(1, 30)) tick();
                if ($urandom_range(0, 1) == 1) annul = 1'b1;
                else start = 1'b0;
                tick();
                annul = 1'b0;
                start = 1'b0;
                tick();
            end else begin
                run(a, b, 1'($urandom_range(0, 1)), 1'b0, 64'd0, $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
